// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse statistics collector.
package pulse_pkg;
  localparam int PULSE_WIDTH_W = 16;
  typedef logic [PULSE_WIDTH_W-1:0] pulse_width_t;
  typedef enum logic {EMPTY, FULL} res_state_t;
  localparam logic [7:0] SAT8_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == SAT8_MAX) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/pulse_stats_collector_if.sv
// Window-result valid/ready bus. stat_avg exists only with PULSE_STATS_AVG_EN.
interface pulse_stats_collector_if #(
  parameter int WIDTH_W     = 16,
  parameter int LOG2_WINDOW = 3
);
  logic                           stat_valid;
  logic                           stat_ready;
  logic [WIDTH_W-1:0]             stat_min;
  logic [WIDTH_W-1:0]             stat_max;
  logic [WIDTH_W+LOG2_WINDOW-1:0] stat_sum;
`ifdef PULSE_STATS_AVG_EN
  logic [WIDTH_W-1:0]             stat_avg;
`endif

  modport master (
    input  stat_ready,
    output stat_valid, stat_min, stat_max, stat_sum
`ifdef PULSE_STATS_AVG_EN
    , stat_avg
`endif
  );
  modport slave (
    output stat_ready,
    input  stat_valid, stat_min, stat_max, stat_sum
`ifdef PULSE_STATS_AVG_EN
    , stat_avg
`endif
  );
endinterface

// File: rtl/pulse_stats_acc.sv
// Per-window min/max/sum/count accumulator. fin_* are the post-sample values,
// valid as the window result in the cycle done is high.
module pulse_stats_acc
  import pulse_pkg::*;
#(
  parameter int WIDTH_W     = PULSE_WIDTH_W,
  parameter int LOG2_WINDOW = 3,
  localparam int SUM_W      = WIDTH_W + LOG2_WINDOW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               accept,
  input  logic [WIDTH_W-1:0] width,
  output logic               done,
  output logic [WIDTH_W-1:0] fin_min,
  output logic [WIDTH_W-1:0] fin_max,
  output logic [SUM_W-1:0]   fin_sum
);
  logic [WIDTH_W-1:0]     acc_min, acc_max;
  logic [SUM_W-1:0]       acc_sum;
  logic [LOG2_WINDOW-1:0] n;

  always_comb begin
    fin_min = (width < acc_min) ? width : acc_min;
    fin_max = (width > acc_max) ? width : acc_max;
    fin_sum = acc_sum + SUM_W'(width);
    done    = accept && (n == '1);
  end

  // A completing sample re-inits the window in the same edge it is reported.
  always_ff @(posedge clk) begin
    if (reset || clear || done) begin
      acc_min <= '1;
      acc_max <= '0;
      acc_sum <= '0;
      n       <= '0;
    end else if (accept) begin
      acc_min <= fin_min;
      acc_max <= fin_max;
      acc_sum <= fin_sum;
      n       <= n + 1'b1;
    end
  end
endmodule

// File: rtl/pulse_stats_collector.sv
// Windowed min/max/sum collector with glitch rejection and a double-buffered
// result register. Optional stat_avg output under PULSE_STATS_AVG_EN.
module pulse_stats_collector
  import pulse_pkg::*;
#(
  parameter int WIDTH_W     = PULSE_WIDTH_W,
  parameter int LOG2_WINDOW = 3,
  parameter int MIN_WIDTH   = 1,
  localparam int SUM_W      = WIDTH_W + LOG2_WINDOW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      width_valid,
  input  logic [WIDTH_W-1:0]        width_in,
  input  logic                      clear,
  pulse_stats_collector_if.master   stat,
  output logic [7:0]                reject_cnt,
  output logic [7:0]                drop_cnt
);
  logic               accept, reject, done, load, drop;
  logic [WIDTH_W-1:0] fin_min, fin_max;
  logic [SUM_W-1:0]   fin_sum;
  res_state_t         state, state_nxt;

  assign accept = width_valid && !clear && (width_in >= WIDTH_W'(MIN_WIDTH));
  assign reject = width_valid && !clear && (width_in <  WIDTH_W'(MIN_WIDTH));

  pulse_stats_acc #(.WIDTH_W(WIDTH_W), .LOG2_WINDOW(LOG2_WINDOW)) u_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .accept (accept),
    .width  (width_in),
    .done   (done),
    .fin_min(fin_min),
    .fin_max(fin_max),
    .fin_sum(fin_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (done) state_nxt = FULL;
      FULL:    if (stat.stat_ready && !done) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // A completion lands only if the slot is free or being drained this cycle.
  always_comb begin
    load = done && ((state == EMPTY) || stat.stat_ready);
    drop = done && (state == FULL) && !stat.stat_ready;
  end

  assign stat.stat_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat.stat_min <= '0;
      stat.stat_max <= '0;
      stat.stat_sum <= '0;
`ifdef PULSE_STATS_AVG_EN
      stat.stat_avg <= '0;
`endif
      reject_cnt    <= '0;
      drop_cnt      <= '0;
    end else begin
      if (load) begin
        stat.stat_min <= fin_min;
        stat.stat_max <= fin_max;
        stat.stat_sum <= fin_sum;
`ifdef PULSE_STATS_AVG_EN
        stat.stat_avg <= WIDTH_W'(fin_sum >> LOG2_WINDOW);
`endif
      end
      if (reject) reject_cnt <= sat_inc8(reject_cnt);
      if (drop)   drop_cnt   <= sat_inc8(drop_cnt);
    end
  end
endmodule

// File: tb/tb_pulse_stats_collector.sv
// Directed bench for pulse_stats_collector with LOG2_WINDOW=2, MIN_WIDTH=2.
module tb_pulse_stats_collector;
  localparam int W = 16;
  localparam int L = 2;
  localparam int S = W + L;

  logic         clk = 0;
  logic         reset = 0;
  logic         width_valid = 0;
  logic [W-1:0] width_in = '0;
  logic         clear = 0;
  logic [7:0]   reject_cnt, drop_cnt;
  int           checks = 0;
  int           errors = 0;

  pulse_stats_collector_if #(.WIDTH_W(W), .LOG2_WINDOW(L)) stat_if ();

  pulse_stats_collector #(.WIDTH_W(W), .LOG2_WINDOW(L), .MIN_WIDTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .width_valid(width_valid),
    .width_in   (width_in),
    .clear      (clear),
    .stat       (stat_if.master),
    .reject_cnt (reject_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic strobe(input logic [W-1:0] w, input logic clr = 1'b0);
    @(negedge clk);
    width_valid = 1'b1;
    width_in    = w;
    clear       = clr;
  endtask

  task automatic idle();
    @(negedge clk);
    width_valid = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; width_valid = 1'b0; clear = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stat_if.stat_ready = 1'b0;
    do_reset();
    checks++; if (stat_if.stat_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0d exp 0", stat_if.stat_valid); end
    checks++; if (stat_if.stat_sum !== '0) begin errors++; $display("FAIL rst_sum got %0d exp 0", stat_if.stat_sum); end
    checks++; if (reject_cnt !== 8'd0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnts got %0d/%0d exp 0/0", reject_cnt, drop_cnt); end
  endtask

  task automatic test_basic();
    stat_if.stat_ready = 1'b1;
    strobe(5); strobe(9); strobe(3); strobe(7);
    idle();
    checks++; if (stat_if.stat_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d exp 1", stat_if.stat_valid); end
    checks++; if (stat_if.stat_min !== 16'd3 || stat_if.stat_max !== 16'd9) begin errors++; $display("FAIL basic_minmax got %0d/%0d exp 3/9", stat_if.stat_min, stat_if.stat_max); end
    checks++; if (stat_if.stat_sum !== 18'd24) begin errors++; $display("FAIL basic_sum got %0d exp 24", stat_if.stat_sum); end
`ifdef PULSE_STATS_AVG_EN
    checks++; if (stat_if.stat_avg !== 16'd6) begin errors++; $display("FAIL basic_avg got %0d exp 6", stat_if.stat_avg); end
`endif
    idle();
    checks++; if (stat_if.stat_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0d exp 0", stat_if.stat_valid); end
  endtask

  task automatic test_reject();
    strobe(0); strobe(1); strobe(4); strobe(4); strobe(4);
    idle();
    checks++; if (stat_if.stat_valid !== 1'b0) begin errors++; $display("FAIL rej_early got %0d exp 0", stat_if.stat_valid); end
    strobe(4);
    idle();
    checks++; if (reject_cnt !== 8'd2) begin errors++; $display("FAIL rej_cnt got %0d exp 2", reject_cnt); end
    checks++; if (stat_if.stat_valid !== 1'b1 || stat_if.stat_min !== 16'd4 || stat_if.stat_max !== 16'd4 || stat_if.stat_sum !== 18'd16)
      begin errors++; $display("FAIL rej_result got v%0d %0d/%0d/%0d exp v1 4/4/16", stat_if.stat_valid, stat_if.stat_min, stat_if.stat_max, stat_if.stat_sum); end
    idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    stat_if.stat_ready = 1'b0;
    strobe(2); strobe(2); strobe(2); strobe(2);
    strobe(8); strobe(8); strobe(8); strobe(8);
    idle();
    checks++; if (stat_if.stat_valid !== 1'b1 || stat_if.stat_sum !== 18'd8 || stat_if.stat_max !== 16'd2)
      begin errors++; $display("FAIL bp_hold got v%0d sum %0d max %0d exp v1 sum 8 max 2", stat_if.stat_valid, stat_if.stat_sum, stat_if.stat_max); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL bp_drop got %0d exp 1", drop_cnt); end
    stat_if.stat_ready = 1'b1;
    idle();
    checks++; if (stat_if.stat_valid !== 1'b0 || stat_if.stat_sum !== 18'd8)
      begin errors++; $display("FAIL bp_release got v%0d sum %0d exp v0 sum 8", stat_if.stat_valid, stat_if.stat_sum); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    stat_if.stat_ready = 1'b0;
    strobe(2); strobe(2); strobe(2); strobe(2);
    strobe(8); strobe(8); strobe(8);
    strobe(8); stat_if.stat_ready = 1'b1;
    idle(); stat_if.stat_ready = 1'b0;
    checks++; if (stat_if.stat_valid !== 1'b1 || stat_if.stat_sum !== 18'd32 || stat_if.stat_min !== 16'd8)
      begin errors++; $display("FAIL b2b_load got v%0d sum %0d min %0d exp v1 sum 32 min 8", stat_if.stat_valid, stat_if.stat_sum, stat_if.stat_min); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL b2b_drop got %0d exp 0", drop_cnt); end
    idle();
    checks++; if (stat_if.stat_valid !== 1'b1 || stat_if.stat_sum !== 18'd32)
      begin errors++; $display("FAIL b2b_hold got v%0d sum %0d exp v1 sum 32", stat_if.stat_valid, stat_if.stat_sum); end
  endtask

  task automatic test_clear();
    do_reset();
    stat_if.stat_ready = 1'b1;
    strobe(6); strobe(6); strobe(6, 1'b1);
    strobe(3); strobe(3); strobe(3);
    idle();
    checks++; if (stat_if.stat_valid !== 1'b0) begin errors++; $display("FAIL clr_early got %0d exp 0", stat_if.stat_valid); end
    strobe(3);
    idle();
    checks++; if (stat_if.stat_valid !== 1'b1 || stat_if.stat_min !== 16'd3 || stat_if.stat_max !== 16'd3 || stat_if.stat_sum !== 18'd12)
      begin errors++; $display("FAIL clr_result got v%0d %0d/%0d/%0d exp v1 3/3/12", stat_if.stat_valid, stat_if.stat_min, stat_if.stat_max, stat_if.stat_sum); end
    checks++; if (reject_cnt !== 8'd0) begin errors++; $display("FAIL clr_rej got %0d exp 0", reject_cnt); end
    idle();
  endtask

  task automatic test_all_ones();
    stat_if.stat_ready = 1'b1;
    for (int i = 0; i < 4; i++) strobe(16'hFFFF);
    idle();
    checks++; if (stat_if.stat_sum !== 18'h3FFFC || stat_if.stat_min !== 16'hFFFF || stat_if.stat_max !== 16'hFFFF)
      begin errors++; $display("FAIL ones_result got %0h/%0h/%0h exp ffff/ffff/3fffc", stat_if.stat_min, stat_if.stat_max, stat_if.stat_sum); end
`ifdef PULSE_STATS_AVG_EN
    checks++; if (stat_if.stat_avg !== 16'hFFFF) begin errors++; $display("FAIL ones_avg got %0h exp ffff", stat_if.stat_avg); end
`endif
    idle();
  endtask

  task automatic test_reject_sat();
    do_reset();
    for (int i = 0; i < 258; i++) strobe(1);
    idle();
    checks++; if (reject_cnt !== 8'd255) begin errors++; $display("FAIL rej_sat got %0d exp 255", reject_cnt); end
  endtask

  task automatic test_mid_reset();
    stat_if.stat_ready = 1'b0;
    strobe(2); strobe(2); strobe(2); strobe(2);
    strobe(0); strobe(5);
    idle();
    checks++; if (stat_if.stat_valid !== 1'b1 || reject_cnt !== 8'd255) begin errors++; $display("FAIL mrst_pre got v%0d rej %0d exp v1 rej 255", stat_if.stat_valid, reject_cnt); end
    do_reset();
    checks++; if (stat_if.stat_valid !== 1'b0 || stat_if.stat_min !== '0 || stat_if.stat_max !== '0 || stat_if.stat_sum !== '0 || reject_cnt !== 8'd0 || drop_cnt !== 8'd0)
      begin errors++; $display("FAIL mrst_zero got v%0d %0d/%0d/%0d rej %0d drop %0d exp all 0", stat_if.stat_valid, stat_if.stat_min, stat_if.stat_max, stat_if.stat_sum, reject_cnt, drop_cnt); end
    stat_if.stat_ready = 1'b1;
    strobe(2); strobe(4); strobe(6);
    idle();
    checks++; if (stat_if.stat_valid !== 1'b0) begin errors++; $display("FAIL mrst_early got %0d exp 0", stat_if.stat_valid); end
    strobe(8);
    idle();
    checks++; if (stat_if.stat_valid !== 1'b1 || stat_if.stat_min !== 16'd2 || stat_if.stat_max !== 16'd8 || stat_if.stat_sum !== 18'd20)
      begin errors++; $display("FAIL mrst_result got v%0d %0d/%0d/%0d exp v1 2/8/20", stat_if.stat_valid, stat_if.stat_min, stat_if.stat_max, stat_if.stat_sum); end
`ifdef PULSE_STATS_AVG_EN
    checks++; if (stat_if.stat_avg !== 16'd5) begin errors++; $display("FAIL mrst_avg got %0d exp 5", stat_if.stat_avg); end
`endif
  endtask

  initial begin
    stat_if.stat_ready = 1'b0;
    test_reset();
    test_basic();
    test_reject();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_all_ones();
    test_reject_sat();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_stats_collector.md
Name: pulse_stats_collector

Overview:
- Downstream consumer of the pulse width detector's measured-width output.
- Collects widths over a fixed window of 2^LOG2_WINDOW accepted pulses and reports min, max and sum per window over a valid/ready result interface.
- Rejects glitch widths below MIN_WIDTH and counts them.
- Double-buffered: accumulation continues while a result waits for acceptance.

Parameters:
- WIDTH_W, 16, bit width of incoming pulse widths and of min/max outputs.
- LOG2_WINDOW, 3, window length = 2^LOG2_WINDOW accepted samples (range 1..8).
- MIN_WIDTH, 1, widths strictly below this are rejected as glitches.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- width_valid  input  1  one-cycle strobe; width_in is sampled when high.
- width_in  input  WIDTH_W  measured pulse width.
- clear  input  1  synchronous abort of the current partial window.
- stat_valid  output  1  result registers hold an unaccepted window result.
- stat_ready  input  1  consumer accepts the result.
- stat_min  output  WIDTH_W  minimum width in the window.
- stat_max  output  WIDTH_W  maximum width in the window.
- stat_sum  output  WIDTH_W+LOG2_WINDOW  sum of widths in the window; cannot overflow.
- reject_cnt  output  8  count of rejected samples, saturating at 255.
- drop_cnt  output  8  count of window results lost to backpressure, saturating at 255.

Behaviour:
- Reset (synchronous, active-high, highest priority): stat_valid, stat_min, stat_max, stat_sum, reject_cnt and drop_cnt all become 0. Internal state: acc_min = all-ones, acc_max = 0, acc_sum = 0, sample counter n = 0.
- Accept rule: width_valid=1, clear=0 and width_in >= MIN_WIDTH.
  - On accept: acc_min = min(acc_min, width_in); acc_max = max(acc_max, width_in); acc_sum += width_in; n += 1.
- Reject rule: width_valid=1, clear=0 and width_in < MIN_WIDTH.
  - On reject: reject_cnt increments, saturating at 255. Accumulators are untouched.
- Window complete: the cycle that accepts the sample making n == 2^LOG2_WINDOW.
  - The final values, including that sample, are offered to the result registers.
  - Accumulators re-init in the same edge (min all-ones, max 0, sum 0, n 0).
  - Latency: stat_valid rises the cycle after the last sample's strobe.
- Result register FSM, states EMPTY and FULL:
  - EMPTY, window complete: load the result, go to FULL.
  - FULL, stat_ready=1, no completion: go to EMPTY (stat_valid=0).
  - FULL, stat_ready=1, completion in the same cycle: load the new result, stay FULL. Not a drop.
  - FULL, stat_ready=0, completion: keep the old result, discard the new one, drop_cnt increments (saturating).
- While stat_valid=1 and stat_ready=0, stat_min, stat_max and stat_sum hold stable.
- clear:
  - Re-inits the accumulators and n only. Does not affect the result registers, reject_cnt or drop_cnt.
  - clear together with width_valid in the same cycle: clear wins, the sample is neither accepted nor rejected.
- Equal widths are valid samples; min can equal max.
- Widths of all-ones are legal.

Optional Feature:
- Macro: PULSE_STATS_AVG_EN.
- Defined: adds output stat_avg (WIDTH_W), loaded with acc_sum >> LOG2_WINDOW at the same edge as stat_sum. Resets to 0 and obeys the same hold/drop rules.
- Undefined: the stat_avg port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pulse_pkg holds:
  - constant PULSE_WIDTH_W = 16;
  - typedef pulse_width_t;
  - enum res_state_t {EMPTY, FULL};
  - constant SAT8_MAX = 8'hFF.
- One sub-module, pulse_stats_acc: the min/max/sum/n accumulator with init, accept and clear inputs and a done output.
- Top level keeps the result FSM, the result registers and the saturating counters.

Test Plan (LOG2_WINDOW=2, MIN_WIDTH=2):
- Strobes 5,9,3,7, stat_ready=1 → one cycle after the 7, stat_valid=1 with min=3, max=9, sum=24; with PULSE_STATS_AVG_EN, stat_avg=6. stat_valid drops the following cycle.
- Strobes 0,1,4,4,4,4 → reject_cnt=2; result min=4, max=4, sum=16.
- stat_ready=0, two full windows (1st: 2,2,2,2; 2nd: 8,8,8,8) → outputs hold sum=8, drop_cnt=1. Raising stat_ready clears stat_valid; outputs still show sum=8.
- stat_valid=1 with window 1 (sum=8); stat_ready pulsed in the same cycle window 2 (sum=32) completes → stat_valid stays 1, sum=32, drop_cnt=0.
- Strobes 6,6, then clear together with a strobe of 6, then 3,3,3,3 → result min=3, sum=12; reject_cnt unchanged.
- reset asserted mid-window with stat_valid=1 → next cycle all outputs 0. A fresh window 2,4,6,8 yields min=2, max=8, sum=20.
